// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, taken-branch flushes, memory waits.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [2:0]       exmem_M,
  input  logic [7:0]       exmem_status,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            branch_taken, load_use, timeout, mem_stall;
  logic            unused_status;

  assign unused_status = ^exmem_status[7:1];

  assign mem_req      = exmem_M[1] | exmem_M[0];
  assign branch_taken = exmem_M[2] & exmem_status[0];
  assign load_use     = idex_mem_read & (idex_rt != 5'd0) &
                        ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));

  // A timed-out access is treated as complete, so it never counts as a stall cycle.
  assign timeout   = (state == MEM_WAIT) & mem_req & ~mem_ready &
                     (to_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign mem_stall = mem_req & ~mem_ready & (state != LD_STALL) & ~timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      mem_err <= mem_err | timeout;
    end
  end

  always_comb begin
    state_nxt   = RUN;
    to_cnt_nxt  = '0;
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      state_nxt   = MEM_WAIT;
      to_cnt_nxt  = to_cnt + TO_W'(1);
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken) begin
      // Younger instructions are squashed, so a coincident load-use needs no stall.
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use && state == RUN) begin
      state_nxt   = LD_STALL;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + CNT_W'(1);
      if (branch_taken && !mem_stall && flush_q != {CNT_W{1'b1}})
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic id_uses_rt = 1'b0, idex_mem_read = 1'b0, mem_ready = 1'b1;
  logic [2:0] exmem_M = '0;
  logic [7:0] exmem_status = '0;
  logic pc_write, pc_src, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive stalled memory cycles, whether last cycle was a load-use stall
  int wait_n = 0;
  bit ld_prev = 0;
  bit err_m = 0;
  int stall_m = 0;
  int flush_m = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(7), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .exmem_M(exmem_M),
    .exmem_status(exmem_status), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_src(pc_src), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mem_req(mem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkCounters();
`ifdef HAZ_PERF_EN
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    checkOutput("flush_cnt", 32'(flush_cnt), 32'(flush_m));
`else
    checkOutput("stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic mr, input logic [4:0] irt, input logic [2:0] m,
                               input logic [7:0] st, input logic rdy);
    bit in_wait, req, br, lu, tmo, memev, br_ev, lu_ev;
    bit e_pw, e_src, e_wr, e_ifl, e_idfl, e_exfl, e_mwfl;
    id_rs = rs; id_rt = rt; id_uses_rt = uses; idex_mem_read = mr;
    idex_rt = irt; exmem_M = m; exmem_status = st; mem_ready = rdy;
    #1;
    in_wait = (wait_n > 0);
    req   = m[1] | m[0];
    br    = m[2] & st[0];
    lu    = mr && (irt != 0) && ((irt == rs) || (uses && irt == rt));
    tmo   = in_wait && req && !rdy && (wait_n == MEM_TIMEOUT - 1);
    memev = req && !rdy && !ld_prev && !tmo;
    br_ev = !memev && br;
    lu_ev = !memev && !br && lu && !in_wait && !ld_prev;
    e_pw   = !memev && !lu_ev;
    e_src  = br_ev;
    e_wr   = !memev && !lu_ev;
    e_ifl  = br_ev;
    e_idfl = br_ev || lu_ev;
    e_exfl = br_ev;
    e_mwfl = memev;
    checkOutput("pc_write", 32'(pc_write), 32'(e_pw));
    checkOutput("pc_src", 32'(pc_src), 32'(e_src));
    checkOutput("ifid_write", 32'(ifid_write), 32'(e_wr));
    checkOutput("idex_write", 32'(idex_write), 32'(!memev));
    checkOutput("exmem_write", 32'(exmem_write), 32'(!memev));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_ifl));
    checkOutput("idex_flush", 32'(idex_flush), 32'(e_idfl));
    checkOutput("exmem_flush", 32'(exmem_flush), 32'(e_exfl));
    checkOutput("memwb_flush", 32'(memwb_flush), 32'(e_mwfl));
    checkOutput("mem_req", 32'(mem_req), 32'(req));
    checkOutput("mem_err", 32'(mem_err), 32'(err_m));
    checkCounters();
    @(posedge clk);
    wait_n  = memev ? wait_n + 1 : 0;
    ld_prev = lu_ev;
    err_m   = err_m | tmo;
    if (!e_pw && stall_m < CNT_MAX) stall_m++;
    if (br_ev && flush_m < CNT_MAX) flush_m++;
    @(negedge clk);
  endtask

  // Reset takes effect at once, without waiting for a clock edge.
  task automatic applyReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst pc_write", 32'(pc_write), 32'd0);
    checkOutput("rst writes", 32'({ifid_write, idex_write, exmem_write}), 32'd0);
    checkOutput("rst flushes", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'hf);
    checkOutput("rst pc_src", 32'(pc_src), 32'd0);
    checkOutput("rst mem_err", 32'(mem_err), 32'd0);
    checkOutput("rst stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n = 0; ld_prev = 0; err_m = 0; stall_m = 0; flush_m = 0;
  endtask

  initial begin
    @(negedge clk);
    applyReset();

    // Load-use on rs: stall, one LD_STALL cycle with the same inputs, then RUN
    applyStimulus(5, 0, 0, 1, 5, 3'b000, 8'h00, 1);
    applyStimulus(5, 0, 0, 1, 5, 3'b000, 8'h00, 1);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 8'h00, 1);
    // Load-use through rt, and rt ignored when not used
    applyStimulus(1, 7, 1, 1, 7, 3'b000, 8'h00, 1);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 8'h00, 1);
    applyStimulus(1, 7, 0, 1, 7, 3'b000, 8'h00, 1);
    // Register $0 never stalls
    applyStimulus(0, 0, 1, 1, 0, 3'b000, 8'h00, 1);
    // Taken and not-taken branch
    applyStimulus(1, 2, 0, 0, 0, 3'b100, 8'h01, 1);
    applyStimulus(1, 2, 0, 0, 0, 3'b100, 8'h00, 1);
    // Branch and load-use together: branch wins, hazard seen again in RUN next cycle
    applyStimulus(5, 0, 0, 1, 5, 3'b100, 8'h01, 1);
    applyStimulus(5, 0, 0, 1, 5, 3'b000, 8'h00, 1);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 8'h00, 1);

    // Memory wait of three cycles
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 2, 0, 0, 0, 3'b010, 8'h00, 0);
    applyStimulus(1, 2, 0, 0, 0, 3'b010, 8'h00, 1);
`ifdef HAZ_PERF_EN
    checkOutput("memwait stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Timeout: mem_err is raised and stays until reset
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 0, 0, 0, 3'b001, 8'h00, 0);
    checkOutput("timeout mem_err", 32'(mem_err), 32'd1);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 8'h00, 1);
    applyStimulus(1, 2, 0, 0, 0, 3'b000, 8'h00, 1);
    checkOutput("sticky mem_err", 32'(mem_err), 32'd1);

    // Reset in the middle of a memory wait
    applyReset();
    applyStimulus(1, 2, 0, 0, 0, 3'b010, 8'h00, 0);
    applyStimulus(1, 2, 0, 0, 0, 3'b010, 8'h00, 0);
    applyReset();

    // Randomized traffic, alternating fast and slow memory phases
    for (int i = 0; i < 800; i++) begin
      bit slow;
      slow = ((i / 50) % 2) == 1;
      if ($urandom_range(0, 99) == 0) applyReset();
      else applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                         8'($urandom), slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
